// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop,
// then samples the device ACK. Drives the shared open-drain pads through active-high OE outputs.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_MAX  = IW'(INHIBIT_CYCLES);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StInhibit, StRts, StAck, StFinish} state_e;

  state_e        state;
  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          fall;
  logic          timeout;
  logic [7:0]    data_q;
  logic          par_q;
  logic [3:0]    n_q;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] t_cnt;

  // Synchronisers reset to the idle-high line level so reset release never looks like a fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clock_in};
      dat_sync <= {dat_sync[0], ps2_data_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign timeout = (t_cnt == T_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      data_q       <= 8'h00;
      par_q        <= 1'b0;
      n_q          <= 4'd0;
      inh_cnt      <= '0;
      t_cnt        <= '0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        StIdle: begin
          if (tx_start) begin
            data_q       <= tx_data;
            par_q        <= ~^tx_data;
            n_q          <= 4'd0;
            t_cnt        <= '0;
            inh_cnt      <= '0;
            tx_busy      <= 1'b1;
            ps2_clock_oe <= 1'b1;
            ps2_data_oe  <= (INHIBIT_CYCLES <= 1);
            state        <= StInhibit;
          end
        end
        StInhibit: begin
          if (inh_cnt != INH_MAX) inh_cnt <= inh_cnt + IW'(1);
          // Start bit goes low during the final inhibit cycle.
          if (inh_cnt == INH_PRE) ps2_data_oe <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b1;
            state        <= StRts;
          end
        end
        StRts: begin
          if (fall) begin
            t_cnt <= '0;
            n_q   <= n_q + 4'd1;
            case (n_q)
              4'd8:    ps2_data_oe <= ~par_q;
              4'd9: begin
                ps2_data_oe <= 1'b0;
                state       <= StAck;
              end
              default: ps2_data_oe <= ~data_q[n_q[2:0]];
            endcase
          end else if (timeout) begin
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            tx_done      <= 1'b1;
            tx_error     <= 1'b1;
            state        <= StFinish;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end
        StAck: begin
          if (fall) begin
            t_cnt    <= '0;
            n_q      <= n_q + 4'd1;
            tx_done  <= 1'b1;
            tx_error <= dat_sync[1];
            state    <= StFinish;
          end else if (timeout) begin
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            tx_done      <= 1'b1;
            tx_error     <= 1'b1;
            state        <= StFinish;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end
        StFinish: begin
          tx_busy <= 1'b0;
          state   <= StIdle;
        end
        default: begin
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
          tx_busy      <= 1'b0;
          state        <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks bits out and checks them against a
// scoreboard of expected line values; a done monitor checks tx_error against queued outcomes.
module tb_ps2_host_tx;

  localparam int unsigned INH = 10;
  localparam int unsigned TMO = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       dev_clk;
  logic       dev_data;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic bit_q[$];
  logic err_q[$];

  // Open-drain pads: either side can pull low.
  assign ps2_clock_in = ps2_clock_oe ? 1'b0 : dev_clk;
  assign ps2_data_in  = ps2_data_oe ? 1'b0 : dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (tx_done) begin
      check_eq("done_expected", 32'(err_q.size() != 0), 1);
      if (err_q.size() != 0) check_eq("tx_error", 32'(tx_error), 32'(err_q.pop_front()));
      check_eq("oe_at_done", {ps2_clock_oe, ps2_data_oe}, 0);
      check_eq("busy_at_done", 32'(tx_busy), 1);
      done_cnt++;
    end
  end

  // Expected line values at each device rising edge: data LSB first, odd parity, stop.
  task automatic push_bits(input logic [7:0] d);
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    bit_q.push_back(~^d);
    bit_q.push_back(1'b1);
  endtask

  task automatic start_xfer(input logic [7:0] d);
    int cnt = 0;
    int dcnt = 0;
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    check_eq("busy_on_accept", 32'(tx_busy), 1);
    while (ps2_clock_oe && cnt < 1000) begin
      cnt++;
      if (ps2_data_oe) dcnt++;
      tick(1);
    end
    check_eq("inhibit_len", cnt, INH);
    check_eq("start_bit_cycles", dcnt, 1);
  endtask

  task automatic dev_xfer(input int nbits, input bit do_ack, input bit ack_val, input int long_k);
    int w = 0;
    while (!(ps2_data_oe && !ps2_clock_oe) && w < 100) begin
      tick(1);
      w++;
    end
    check_eq("rts_seen", 32'(ps2_data_oe && !ps2_clock_oe), 1);
    tick(10);
    for (int k = 1; k <= nbits; k++) begin
      dev_clk = 1'b0;
      tick(20);
      dev_clk = 1'b1;
      if (bit_q.size() != 0) check_eq($sformatf("bit%0d", k), 32'(ps2_data_in), 32'(bit_q.pop_front()));
      tick(20);
      if (k == long_k) tick(160);
    end
    if (do_ack) begin
      dev_data = ack_val;
      tick(5);
      dev_clk = 1'b0;
      tick(20);
      dev_clk = 1'b1;
      tick(5);
      dev_data = 1'b1;
      tick(20);
    end
  endtask

  task automatic wait_done(input int prev, input int budget, output int waited);
    waited = 0;
    while (done_cnt == prev && waited < budget) begin
      tick(1);
      waited++;
    end
    check_eq("done_arrived", 32'(done_cnt != prev), 1);
  endtask

  task automatic full_xfer(input logic [7:0] d, input bit ack_val, input int long_k);
    int prev;
    int waited;
    prev = done_cnt;
    push_bits(d);
    err_q.push_back(ack_val);
    start_xfer(d);
    dev_xfer(10, 1'b1, ack_val, long_k);
    wait_done(prev, 50, waited);
    tick(1);
    check_eq("busy_after", 32'(tx_busy), 0);
    check_eq("oe_after", {ps2_clock_oe, ps2_data_oe}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int prev;
    int waited;
    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tick(3);
    check_eq("rst_oe", {ps2_clock_oe, ps2_data_oe}, 0);
    check_eq("rst_flags", {tx_busy, tx_done, tx_error}, 0);
    reset = 1'b0;
    tick(3);

    // 0xED with ACK
    full_xfer(8'hED, 1'b0, 0);
    // parity corners
    full_xfer(8'h00, 1'b0, 0);
    full_xfer(8'hFF, 1'b0, 0);
    // NAK at ACK edge
    full_xfer(8'hA5, 1'b1, 0);

    // device stops after 4 bits
    prev = done_cnt;
    push_bits(8'h5A);
    err_q.push_back(1'b1);
    start_xfer(8'h5A);
    dev_xfer(4, 1'b0, 1'b0, 0);
    bit_q.delete();
    wait_done(prev, 300, waited);
    check_eq("timeout_window", 32'(waited >= 150 && waited <= 180), 1);
    tick(1);
    check_eq("timeout_oe", {ps2_clock_oe, ps2_data_oe}, 0);
    check_eq("timeout_busy", 32'(tx_busy), 0);

    // start while busy is ignored; reset at n=5 aborts silently
    prev = done_cnt;
    push_bits(8'hED);
    start_xfer(8'hED);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    check_eq("busy_start_ignored", {ps2_clock_oe, ps2_data_oe, tx_busy}, 3'b011);
    dev_xfer(5, 1'b0, 1'b0, 0);
    tick(6);
    #2;
    reset = 1'b1;
    #1;
    check_eq("reset_mid_oe", {ps2_clock_oe, ps2_data_oe}, 0);
    check_eq("reset_mid_flags", {tx_busy, tx_done, tx_error}, 0);
    tick(2);
    reset = 1'b0;
    bit_q.delete();
    tick(5);
    check_eq("no_done_on_reset", done_cnt, prev);
    full_xfer(8'h3C, 1'b0, 0);

    // fall arrives with timeout counter at TMO-1
    full_xfer(8'h96, 1'b0, 5);

    check_eq("err_q_empty", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
